// File: rtl/mcpu_ram_sync_if.sv
// Bus between the MCPU core (fetch + load/store units) and the synchronous RAM controller.
interface mcpu_ram_if #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  datawr;
    logic [WORD_SIZE-1:0]  datard;
    logic                  drvalid;
    logic                  ire;
    logic [ADDR_WIDTH-1:0] instraddr;
    logic [WORD_SIZE-1:0]  instrrd;
    logic                  irvalid;
    logic                  busy;

    modport master (
        output we, re, addr, datawr, ire, instraddr,
        input  datard, drvalid, instrrd, irvalid, busy
    );

    modport slave (
        input  we, re, addr, datawr, ire, instraddr,
        output datard, drvalid, instrrd, irvalid, busy
    );
endinterface

// File: rtl/mcpu_ram_sync_ctrl.sv
// Synchronous two-port RAM controller for the MCPU: data port (read/write),
// instruction-fetch port (read-only), registered reads with valid strobes,
// write-first forwarding and an optional post-reset zero-fill.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zero-fill in progress, one word per cycle; requests ignored
// S_RUN   | normal operation until the next reset
module mcpu_ram_sync_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset,
    mcpu_ram_if.slave   bus
);
    localparam int RAM_SIZE = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  fill_we;
    logic                  fill_last;
    logic                  run;
    logic [WORD_SIZE-1:0]  mem [RAM_SIZE];

    assign run      = (state_q == S_RUN);
    assign bus.busy = (state_q == S_CLEAR);

    // State register; reset picks the fill or skips straight to normal operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave CLEAR once the last address has been written.
    always_comb begin
        state_d   = state_q;
        fill_we   = 1'b0;
        fill_last = (cnt_q == LAST_ADDR);
        case (state_q)
            S_CLEAR: begin
                fill_we = 1'b1;
                if (fill_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Fill address counter; parks at the last address instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (fill_we && !fill_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // RAM array: fill writes take priority; no write on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_we) begin
                mem[cnt_q] <= '0;
            end else if (run && bus.we) begin
                mem[bus.addr] <= bus.datawr;
            end
        end
    end

    // Data read port, write-first on same-address collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.datard  <= '0;
            bus.drvalid <= 1'b0;
        end else begin
            bus.drvalid <= run && bus.re;
            if (run && bus.re) begin
                bus.datard <= bus.we ? bus.datawr : mem[bus.addr];
            end
        end
    end

    // Instruction read port, forwards a same-cycle data write to its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.instrrd <= '0;
            bus.irvalid <= 1'b0;
        end else begin
            bus.irvalid <= run && bus.ire;
            if (run && bus.ire) begin
                if (bus.we && (bus.addr == bus.instraddr)) begin
                    bus.instrrd <= bus.datawr;
                end else begin
                    bus.instrrd <= mem[bus.instraddr];
                end
            end
        end
    end
endmodule

// File: tb/tb_mcpu_ram_sync_ctrl.sv
// Directed bench for mcpu_ram_sync_ctrl: one instance with zero-fill, one without.
module tb_mcpu_ram_sync_ctrl;
    logic clk;
    logic reset_a;
    logic reset_b;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] model [16];

    mcpu_ram_if #(.WORD_SIZE(8), .ADDR_WIDTH(4)) a_if ();
    mcpu_ram_if #(.WORD_SIZE(8), .ADDR_WIDTH(4)) b_if ();

    mcpu_ram_sync_ctrl #(.WORD_SIZE(8), .ADDR_WIDTH(4), .INIT_CLEAR(1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (a_if.slave)
    );

    mcpu_ram_sync_ctrl #(.WORD_SIZE(8), .ADDR_WIDTH(4), .INIT_CLEAR(0)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.we = 1'b0; a_if.re = 1'b0; a_if.ire = 1'b0;
        a_if.addr = '0; a_if.instraddr = '0; a_if.datawr = '0;
    endtask

    task automatic idle_b();
        b_if.we = 1'b0; b_if.re = 1'b0; b_if.ire = 1'b0;
        b_if.addr = '0; b_if.instraddr = '0; b_if.datawr = '0;
    endtask

    task automatic test_reset();
        int n;
        reset_a = 1'b1;
        a_if.we = 1'b1; a_if.re = 1'b1; a_if.ire = 1'b1;
        a_if.addr = 4'd4; a_if.instraddr = 4'd4; a_if.datawr = 8'h77;
        tick();
        checks++;
        if (a_if.datard !== 8'h00 || a_if.instrrd !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: datard=%h instrrd=%h expected 00 00", a_if.datard, a_if.instrrd);
        end
        checks++;
        if (a_if.drvalid !== 1'b0 || a_if.irvalid !== 1'b0 || a_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: drvalid=%b irvalid=%b busy=%b expected 0 0 1",
                     a_if.drvalid, a_if.irvalid, a_if.busy);
        end
        idle_a();
        reset_a = 1'b0;
        n = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL fill_cycles: got %0d expected 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            a_if.re = 1'b1;
            a_if.addr = 4'(i);
            tick();
            checks++;
            if (a_if.datard !== 8'h00 || a_if.drvalid !== 1'b1) begin
                errors++;
                $display("FAIL fill_read[%0d]: datard=%h drvalid=%b expected 00 1", i, a_if.datard, a_if.drvalid);
            end
        end
        a_if.re = 1'b0;
        tick();
        checks++;
        if (a_if.drvalid !== 1'b0) begin
            errors++;
            $display("FAIL drvalid_drop: got %b expected 0", a_if.drvalid);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'(i * 37 + 11);
            a_if.we = 1'b1;
            a_if.addr = 4'(i);
            a_if.datawr = model[i];
            tick();
        end
        a_if.we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_if.re = 1'b1;
            a_if.addr = 4'(i);
            a_if.ire = 1'b1;
            a_if.instraddr = 4'(15 - i);
            tick();
            checks++;
            if (a_if.datard !== model[i] || a_if.drvalid !== 1'b1) begin
                errors++;
                $display("FAIL data_read[%0d]: datard=%h drvalid=%b expected %h 1",
                         i, a_if.datard, a_if.drvalid, model[i]);
            end
            checks++;
            if (a_if.instrrd !== model[15 - i] || a_if.irvalid !== 1'b1) begin
                errors++;
                $display("FAIL instr_read[%0d]: instrrd=%h irvalid=%b expected %h 1",
                         15 - i, a_if.instrrd, a_if.irvalid, model[15 - i]);
            end
        end
        idle_a();
        tick();
    endtask

    task automatic test_collision();
        a_if.we = 1'b1; a_if.addr = 4'd5; a_if.datawr = 8'h11;
        tick();
        a_if.addr = 4'd6; a_if.datawr = 8'h66;
        tick();
        a_if.we = 1'b1; a_if.re = 1'b1; a_if.ire = 1'b1;
        a_if.addr = 4'd5; a_if.instraddr = 4'd5; a_if.datawr = 8'hA5;
        tick();
        checks++;
        if (a_if.datard !== 8'hA5 || a_if.instrrd !== 8'hA5) begin
            errors++;
            $display("FAIL coll_same: datard=%h instrrd=%h expected a5 a5", a_if.datard, a_if.instrrd);
        end
        a_if.instraddr = 4'd6; a_if.datawr = 8'h5A;
        tick();
        checks++;
        if (a_if.datard !== 8'h5A || a_if.instrrd !== 8'h66) begin
            errors++;
            $display("FAIL coll_diff: datard=%h instrrd=%h expected 5a 66", a_if.datard, a_if.instrrd);
        end
        idle_a();
        a_if.re = 1'b1; a_if.addr = 4'd5; a_if.ire = 1'b1; a_if.instraddr = 4'd5;
        tick();
        checks++;
        if (a_if.datard !== 8'h5A || a_if.instrrd !== 8'h5A) begin
            errors++;
            $display("FAIL coll_stored: datard=%h instrrd=%h expected 5a 5a", a_if.datard, a_if.instrrd);
        end
        idle_a();
        tick();
    endtask

    task automatic test_busy_gating();
        int n;
        int bad;
        reset_a = 1'b1;
        idle_a();
        tick();
        reset_a = 1'b0;
        a_if.we = 1'b1; a_if.addr = 4'd3; a_if.datawr = 8'hFF;
        a_if.re = 1'b1; a_if.ire = 1'b1; a_if.instraddr = 4'd3;
        n = 0;
        bad = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            if (a_if.drvalid !== 1'b0 || a_if.irvalid !== 1'b0 || a_if.datard !== 8'h00) bad++;
            n++;
            tick();
        end
        checks++;
        if (a_if.drvalid !== 1'b0 || a_if.irvalid !== 1'b0) bad++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_gating: got %0d bad cycles expected 0", bad);
        end
        idle_a();
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL gated_fill_cycles: got %0d expected 16", n);
        end
        a_if.re = 1'b1; a_if.addr = 4'd3;
        tick();
        checks++;
        if (a_if.datard !== 8'h00 || a_if.drvalid !== 1'b1) begin
            errors++;
            $display("FAIL gated_mem3: datard=%h drvalid=%b expected 00 1", a_if.datard, a_if.drvalid);
        end
        idle_a();
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        reset_a = 1'b1;
        idle_a();
        tick();
        reset_a = 1'b0;
        repeat (7) tick();
        checks++;
        if (a_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b expected 1", a_if.busy);
        end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        n = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL refill_cycles: got %0d expected 16", n);
        end
        a_if.we = 1'b1; a_if.addr = 4'd2; a_if.datawr = 8'hC3;
        tick();
        a_if.we = 1'b0; a_if.re = 1'b1; a_if.ire = 1'b1; a_if.instraddr = 4'd2;
        tick();
        checks++;
        if (a_if.datard !== 8'hC3 || a_if.instrrd !== 8'hC3) begin
            errors++;
            $display("FAIL run_read: datard=%h instrrd=%h expected c3 c3", a_if.datard, a_if.instrrd);
        end
        idle_a();
        reset_a = 1'b1;
        tick();
        checks++;
        if (a_if.datard !== 8'h00 || a_if.instrrd !== 8'h00 || a_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL run_reset: datard=%h instrrd=%h busy=%b expected 00 00 1",
                     a_if.datard, a_if.instrrd, a_if.busy);
        end
        reset_a = 1'b0;
        n = 0;
        while (a_if.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL run_refill_cycles: got %0d expected 16", n);
        end
        a_if.re = 1'b1; a_if.addr = 4'd2;
        tick();
        checks++;
        if (a_if.datard !== 8'h00 || a_if.drvalid !== 1'b1) begin
            errors++;
            $display("FAIL refill_mem2: datard=%h drvalid=%b expected 00 1", a_if.datard, a_if.drvalid);
        end
        idle_a();
        tick();
    endtask

    task automatic test_hold_noclear();
        reset_b = 1'b1;
        idle_b();
        tick();
        checks++;
        if (b_if.busy !== 1'b0 || b_if.datard !== 8'h00 || b_if.drvalid !== 1'b0) begin
            errors++;
            $display("FAIL noclear_reset: busy=%b datard=%h drvalid=%b expected 0 00 0",
                     b_if.busy, b_if.datard, b_if.drvalid);
        end
        reset_b = 1'b0;
        b_if.we = 1'b1; b_if.addr = 4'd9; b_if.datawr = 8'h9E;
        tick();
        checks++;
        if (b_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL noclear_busy: got %b expected 0", b_if.busy);
        end
        b_if.we = 1'b0; b_if.re = 1'b1; b_if.ire = 1'b1; b_if.instraddr = 4'd9;
        tick();
        checks++;
        if (b_if.datard !== 8'h9E || b_if.drvalid !== 1'b1 || b_if.instrrd !== 8'h9E || b_if.irvalid !== 1'b1) begin
            errors++;
            $display("FAIL noclear_read: datard=%h drvalid=%b instrrd=%h irvalid=%b expected 9e 1 9e 1",
                     b_if.datard, b_if.drvalid, b_if.instrrd, b_if.irvalid);
        end
        b_if.re = 1'b0; b_if.ire = 1'b0;
        b_if.we = 1'b1; b_if.datawr = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b_if.datard !== 8'h9E || b_if.drvalid !== 1'b0 || b_if.instrrd !== 8'h9E || b_if.irvalid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: datard=%h drvalid=%b instrrd=%h irvalid=%b expected 9e 0 9e 0",
                         k, b_if.datard, b_if.drvalid, b_if.instrrd, b_if.irvalid);
            end
        end
        b_if.we = 1'b0; b_if.re = 1'b1;
        tick();
        checks++;
        if (b_if.datard !== 8'h00 || b_if.drvalid !== 1'b1) begin
            errors++;
            $display("FAIL noclear_overwrite: datard=%h drvalid=%b expected 00 1", b_if.datard, b_if.drvalid);
        end
        idle_b();
        tick();
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        idle_a();
        idle_b();
        tick();
        tick();
        test_reset();
        test_write_read();
        test_collision();
        test_busy_gating();
        test_reset_mid();
        test_hold_noclear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
